systolic_array_controller: RTL
==============================

SYSTOLIC_ARRAY_CONTROLLER -- requirements
Module: systolic_array_controller

Interface
REQ-001 Parameter ARRAY_HEIGHT, default 4: PE rows; weight rows loaded per job.
REQ-002 Parameter ARRAY_WIDTH, default 4: PE columns.
REQ-003 Parameter VEC_ADDR_WIDTH, default 8: width of vector count and ifmap/ofmap addresses.
REQ-004 Parameter OFMAP_LATENCY, default ARRAY_HEIGHT+ARRAY_WIDTH: enabled cycles from an ifmap_rd_en to the matching deskewed output row.
REQ-005 Port clk, input, 1: single clock; all logic on rising edge.
REQ-006 Port rst, input, 1: synchronous, active-high reset.
REQ-007 Port start, input, 1: single-cycle job request; sampled only in IDLE.
REQ-008 Port num_vectors, input, VEC_ADDR_WIDTH: ifmap vectors in the job; captured with start.
REQ-009 Port ofmap_stall, input, 1: downstream not ready; freezes the compute pipeline.
REQ-010 Port weight_rd_en, output, 1: weight SRAM read strobe.
REQ-011 Port weight_rd_addr, output, clog2(ARRAY_HEIGHT): weight row address.
REQ-012 Port weight_write_enable, output, 1: array weight-latch strobe.
REQ-013 Port ifmap_rd_en, output, 1: ifmap SRAM read strobe.
REQ-014 Port ifmap_rd_addr, output, VEC_ADDR_WIDTH: ifmap vector address.
REQ-015 Port array_enable, output, 1: array enable.
REQ-016 Port ofmap_wr_en, output, 1: ofmap SRAM write strobe.
REQ-017 Port ofmap_wr_addr, output, VEC_ADDR_WIDTH: ofmap row address.
REQ-018 Port busy, output, 1: high from the first LOAD cycle through the last ofmap write.
REQ-019 Port done, output, 1: one-cycle completion pulse.

Function
REQ-020 FSM states: IDLE, LOAD, STREAM, DRAIN, DONE; all outputs are registered or decoded from state and counters only.
REQ-021 IDLE: if start=1 and num_vectors!=0, capture num_vectors and go to LOAD; start with num_vectors=0, and start in any other state, are ignored.
REQ-022 LOAD: weight_rd_en=1 for exactly ARRAY_HEIGHT cycles, weight_rd_addr = 0..ARRAY_HEIGHT-1; weight_write_enable follows weight_rd_en delayed by one cycle (1-cycle SRAM latency); then go to STREAM.
REQ-023 ofmap_stall has no effect in LOAD.
REQ-024 STREAM: each non-stalled cycle asserts ifmap_rd_en with ifmap_rd_addr = 0..num_vectors-1 in order; after num_vectors reads, go to DRAIN.
REQ-025 array_enable = 1 in STREAM and DRAIN when ofmap_stall=0; otherwise 0.
REQ-026 A valid shift pipeline of depth OFMAP_LATENCY advances only when array_enable=1; ofmap_wr_en asserts exactly OFMAP_LATENCY enabled cycles after the matching ifmap_rd_en.
REQ-027 ofmap_wr_addr starts at 0 and increments after each write; it never exceeds num_vectors-1.
REQ-028 ofmap_stall=1 in STREAM or DRAIN: ifmap_rd_en, array_enable and ofmap_wr_en are 0, and all counters and the valid pipeline hold. The ifmap SRAM output register holds its data while ifmap_rd_en=0.
REQ-029 DRAIN exits to DONE in the cycle after the write of row num_vectors-1.
REQ-030 DONE lasts one cycle with done=1 and busy=0, then returns to IDLE; a start in DONE is ignored.
REQ-031 Arithmetic: counters are unsigned, sized to their maximum plus one, with no wrap-around in legal operation; num_vectors=2^VEC_ADDR_WIDTH-1 is supported.

Reset
REQ-032 rst=1 forces IDLE, clears all counters and the valid pipeline, and drives every output to 0 on the next edge, including in mid-job; no done pulse is generated for an aborted job.
REQ-033 rst has priority over start and ofmap_stall.

Structure
REQ-034 A shared package holds the FSM state enum and the OFMAP_LATENCY derivation helper.
REQ-035 One sub-module, valid_delay_line: a parameterized-depth 1-bit shift register with an advance enable, used for REQ-026.

Verification (H=W=4, OFMAP_LATENCY=8)
REQ-036 start, num_vectors=3 at cycle 0 -> weight_rd_en cycles 1-4, addr 0-3; weight_write_enable cycles 2-5; ifmap_rd_en cycles 5-7, addr 0-2; ofmap_wr_en cycles 13-15, addr 0-2; done cycle 16; busy cycles 1-15.
REQ-037 Same job with ofmap_stall=1 during cycles 6-7 -> ifmap reads at cycles 5, 8, 9; all later events shift by 2; done at cycle 18; exactly 3 writes.
REQ-038 rst=1 at cycle 10 of the REQ-036 job -> all outputs 0 from cycle 11; no writes and no done; a new start then runs normally.
REQ-039 start while busy, and start with num_vectors=0 -> ignored; no output activity.
REQ-040 num_vectors=255 -> exactly 255 reads and 255 writes, last address 254, single done pulse.

Source files
------------

// File: rtl/systolic_array_controller_pkg.sv
// Shared types and parameter helpers for the systolic array controller.
package systolic_array_controller_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_e;

  // Output rows emerge after the skewed wavefront crosses both array dimensions.
  function automatic int unsigned ofmap_latency(input int unsigned height,
                                                input int unsigned width);
    return height + width;
  endfunction

  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/systolic_array_controller_if.sv
// SRAM/array-side signal bundle driven by the systolic array controller.
interface systolic_array_controller_if
  import systolic_array_controller_pkg::*;
#(
  parameter int unsigned ARRAY_HEIGHT   = 4,
  parameter int unsigned VEC_ADDR_WIDTH = 8
);
  localparam int unsigned WA_W = addr_width(ARRAY_HEIGHT);

  logic                      weight_rd_en;
  logic [WA_W-1:0]           weight_rd_addr;
  logic                      weight_write_enable;
  logic                      ifmap_rd_en;
  logic [VEC_ADDR_WIDTH-1:0] ifmap_rd_addr;
  logic                      array_enable;
  logic                      ofmap_wr_en;
  logic [VEC_ADDR_WIDTH-1:0] ofmap_wr_addr;
  logic                      ofmap_stall;

  modport master (
    output weight_rd_en, weight_rd_addr, weight_write_enable,
    output ifmap_rd_en, ifmap_rd_addr, array_enable,
    output ofmap_wr_en, ofmap_wr_addr,
    input  ofmap_stall
  );

  modport slave (
    input  weight_rd_en, weight_rd_addr, weight_write_enable,
    input  ifmap_rd_en, ifmap_rd_addr, array_enable,
    input  ofmap_wr_en, ofmap_wr_addr,
    output ofmap_stall
  );

endinterface

// File: rtl/systolic_array_controller_valid_delay_line.sv
// 1-bit shift register that only advances when enabled; tracks row validity through the array.
module valid_delay_line #(
  parameter int unsigned DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic advance,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (advance) begin
      sr_d[0] = din;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        sr_d[i] = sr_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/systolic_array_controller.sv
// Sequences weight load, ifmap streaming and ofmap drain for a weight-stationary systolic array.
module systolic_array_controller
  import systolic_array_controller_pkg::*;
#(
  parameter int unsigned ARRAY_HEIGHT   = 4,
  parameter int unsigned ARRAY_WIDTH    = 4,
  parameter int unsigned VEC_ADDR_WIDTH = 8,
  parameter int unsigned OFMAP_LATENCY  = ofmap_latency(ARRAY_HEIGHT, ARRAY_WIDTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [VEC_ADDR_WIDTH-1:0] num_vectors,
  systolic_array_controller_if.master bus,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned WA_W = addr_width(ARRAY_HEIGHT);
  localparam logic [WA_W-1:0] W_LAST = WA_W'(ARRAY_HEIGHT - 1);

  state_e                    state_q, state_d;
  logic [VEC_ADDR_WIDTH-1:0] num_q, num_d;
  logic [WA_W-1:0]           wcnt_q, wcnt_d;
  logic [VEC_ADDR_WIDTH-1:0] rd_q, rd_d;
  logic [VEC_ADDR_WIDTH-1:0] wr_q, wr_d;
  logic                      wwe_q, wwe_d;

  logic computing, arr_en, rd_en, wr_en, row_valid;

  assign computing = (state_q == S_STREAM) || (state_q == S_DRAIN);
  assign arr_en    = computing && !bus.ofmap_stall;
  assign rd_en     = (state_q == S_STREAM) && !bus.ofmap_stall;
  assign wr_en     = arr_en && row_valid;

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    wcnt_d  = wcnt_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    wwe_d   = (state_q == S_LOAD);

    unique case (state_q)
      S_IDLE: begin
        if (start && (num_vectors != '0)) begin
          num_d   = num_vectors;
          wcnt_d  = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (wcnt_q == W_LAST) begin
          wcnt_d  = '0;
          state_d = S_STREAM;
        end else begin
          wcnt_d = wcnt_q + WA_W'(1);
        end
      end
      S_STREAM: begin
        if (rd_en) begin
          if (rd_q == num_q - VEC_ADDR_WIDTH'(1)) begin
            rd_d    = '0;
            state_d = S_DRAIN;
          end else begin
            rd_d = rd_q + VEC_ADDR_WIDTH'(1);
          end
        end
      end
      S_DRAIN: ;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Write address wraps to 0 on the final row so it never reads past num_vectors-1.
    if (wr_en) begin
      if (wr_q == num_q - VEC_ADDR_WIDTH'(1)) begin
        wr_d = '0;
        if (state_q == S_DRAIN) state_d = S_DONE;
      end else begin
        wr_d = wr_q + VEC_ADDR_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      num_q   <= '0;
      wcnt_q  <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      wwe_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      wcnt_q  <= wcnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      wwe_q   <= wwe_d;
    end
  end

  valid_delay_line #(
    .DEPTH(OFMAP_LATENCY)
  ) u_valid_delay_line (
    .clk    (clk),
    .rst    (rst),
    .advance(arr_en),
    .din    (rd_en),
    .dout   (row_valid)
  );

  assign bus.weight_rd_en        = (state_q == S_LOAD);
  assign bus.weight_rd_addr      = (state_q == S_LOAD) ? wcnt_q : '0;
  assign bus.weight_write_enable = wwe_q;
  assign bus.ifmap_rd_en         = rd_en;
  assign bus.ifmap_rd_addr       = (state_q == S_STREAM) ? rd_q : '0;
  assign bus.array_enable        = arr_en;
  assign bus.ofmap_wr_en         = wr_en;
  assign bus.ofmap_wr_addr       = wr_q;
  assign busy                    = (state_q == S_LOAD) || computing;
  assign done                    = (state_q == S_DONE);

endmodule
